lpe_array_scheduler: RTL and testbench
======================================

# lpe_array_scheduler

Job-level sequencer for an I×J output-stationary systolic array of linear processing elements. Accepts a job command (reduction length K). Distributes one serial weight stream round-robin over the array's top-edge columns and one serial data stream round-robin over its left-edge rows, inserting `tuser` and `tlast` framing. Then collects the I×J exported results from the bottom edge and serializes them onto a single result stream. It sits between the DMA/stream fabric and the array and is the only driver of the array edges.

## Interface
- `PE_NUMBER_I`, 4, array columns (top/bottom edge streams)
- `PE_NUMBER_J`, 4, array rows (left edge streams)
- `U_D_WIDTH`, 16, weight / result word width
- `L_R_WIDTH`, 16, data word width
- `USER_WIDTH`, 8, `tuser` width
- `OP1_USER_MASK`, `1<<(USER_WIDTH-2)`, `tuser` tag on weight words
- `RSLT_USER_MASK`, `1<<(USER_WIDTH-1)`, `tuser` tag expected on result words
- `LEN_WIDTH`, 16, width of K
---
- `clk` in 1: sole clock, rising edge
- `rst` in 1: synchronous, active-high
- `s_cmd_tdata` in LEN_WIDTH: K; `s_cmd_tvalid` in 1; `s_cmd_tready` out 1
- `s_axis_w_tdata` in U_D_WIDTH; `s_axis_w_tvalid` in 1; `s_axis_w_tready` out 1: serial weights
- `s_axis_x_tdata` in L_R_WIDTH; `s_axis_x_tvalid` in 1; `s_axis_x_tready` out 1: serial data
- `m_axis_up_tdata` out I*U_D_WIDTH; `m_axis_up_tvalid`/`m_axis_up_tlast` out I; `m_axis_up_tuser` out I*USER_WIDTH; `m_axis_up_tready` in I
- `m_axis_left_tdata` out J*L_R_WIDTH; `m_axis_left_tvalid`/`m_axis_left_tlast` out J; `m_axis_left_tready` in J
- `s_axis_down_tdata` in I*U_D_WIDTH; `s_axis_down_tvalid`/`s_axis_down_tlast` in I; `s_axis_down_tuser` in I*USER_WIDTH; `s_axis_down_tready` out I
- `m_axis_rslt_tdata` out U_D_WIDTH; `m_axis_rslt_tvalid` out 1; `m_axis_rslt_tlast` out 1; `m_axis_rslt_tid` out clog2(I); `m_axis_rslt_tready` in 1
- `busy` out 1; `err_cmd` out 1 (sticky); `err_rslt` out 1 (sticky)

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE:
  - `s_cmd_tready`=1.
  - Cmd handshake with K≥1: latch K, clear counters → FEED.
  - K=0: accepted and discarded, `err_cmd` set, remain IDLE.
- FEED: two independent feeders run concurrently.
  - Weight feeder:
    - Routes `s_axis_w` to column `col_w`: `up_tvalid[col_w]`=`w_tvalid`, `w_tready`=`up_tready[col_w]`.
    - `up_tuser`=OP1_USER_MASK; `up_tlast[col_w]`=(`k_w`==K-1).
    - On handshake `col_w`++; wrap at I-1 → 0 and `k_w`++.
    - Done after K·I words; `w_tready`=0 afterwards.
  - Data feeder: identical, over J rows with `row_x`/`k_x`, K·J words, `left_tlast` on the k=K-1 word.
  - Both done → DRAIN.
- DRAIN:
  - Collects column `c`=0..I-1 in order, J words each.
  - `rslt_tvalid`=`down_tvalid[c]`; `down_tready[c]`=`rslt_tready`; `rslt_tid`=c.
  - `rslt_tlast`=1 on word I·J.
  - Last handshake → IDLE.
- Non-selected lanes: tvalid=0, tready=0.
- `busy`=(state≠IDLE).
- Counter widths: `k_*` LEN_WIDTH; column/row/result counters clog2 of their bound. No wrap beyond bounds.

## Timing
- Edge routing is combinational: zero latency, no buffering. Every output valid and ready depends only on registered counters, plus the corresponding input handshake signal.
- State, counters and sticky flags update on `clk` rising edge.
- Command-to-first-feed: 1 cycle, i.e. first weight/data handshake possible in the cycle after the cmd handshake.
- Last feed handshake → DRAIN next cycle. Last result → IDLE next cycle; a new cmd can be accepted then.
- AXI-Stream rule: no output valid drops without a handshake. Valids depend only on registered counters and input tvalid.
- Reset:
  - While `rst`=1, all outputs are 0 (`s_cmd_tready`=0, `busy`=0, errors 0).
  - First cycle after reset: IDLE, `s_cmd_tready`=1.
  - Reset mid-job aborts immediately. Partial edge transfers are dropped, and the array must be reset in the same cycle.

## Configuration
- `LPE_SCHED_RSLT_CHECK_EN` defined: each DRAIN handshake checks `down_tuser[c] & RSLT_USER_MASK`≠0 and `down_tlast[c]`==(j==J-1). Any mismatch sets `err_rslt`; the word is still forwarded.
- Undefined: no check logic, `err_rslt` tied 0.

## Test plan
- I=J=2, K=3, weights 1..6, data 10..15, all readies 1:
  - Columns receive {1,3,5}/{2,4,6} with tlast on 5 and 6, tuser=0x40.
  - Rows receive {10,12,14}/{11,13,15}, tlast on 14 and 15.
  - `busy` rises the cycle after cmd.
- Same job, results 0xA0..0xA3 (col0: A0,A1; col1: A2,A3) with tuser=0x80 and tlast on the 2nd of each column → `rslt` A0,A1,A2,A3, tid 0,0,1,1, tlast only on A3, IDLE next cycle.
- `up_tready[1]` held 0 for 5 cycles mid-feed → `w_tready`=0 while `col_w`=1. Data feeder continues independently. No word lost or duplicated.
- cmd K=0 → `err_cmd`=1, `busy` stays 0. A following cmd K=1 runs normally.
- `rst` asserted in DRAIN after 1 result → next cycle all valids 0, `busy`=0, `s_cmd_tready`=1.
- With `LPE_SCHED_RSLT_CHECK_EN`: result with tuser=0x00 → `err_rslt`=1 and sticky, word still output. Without the macro: `err_rslt`=0.

Source files
------------

// File: rtl/lpe_array_scheduler.sv
// Job-level sequencer for an I x J output-stationary systolic array.
// It accepts a job (reduction length K) and spreads the serial weight stream over the top
// columns and the serial data stream over the left rows, adding tuser/tlast framing. It then
// collects the I x J results from the bottom edge column by column and serialises them.
// Optional feature: define LPE_SCHED_RSLT_CHECK_EN to check result tuser/tlast framing (err_rslt).
module lpe_array_scheduler #(
  parameter int unsigned PE_NUMBER_I = 4,
  parameter int unsigned PE_NUMBER_J = 4,
  parameter int unsigned U_D_WIDTH = 16,
  parameter int unsigned L_R_WIDTH = 16,
  parameter int unsigned USER_WIDTH = 8,
  parameter logic [USER_WIDTH-1:0] OP1_USER_MASK = USER_WIDTH'(1) << (USER_WIDTH - 2),
  parameter logic [USER_WIDTH-1:0] RSLT_USER_MASK = USER_WIDTH'(1) << (USER_WIDTH - 1),
  parameter int unsigned LEN_WIDTH = 16,
  localparam int unsigned IW = (PE_NUMBER_I > 1) ? $clog2(PE_NUMBER_I) : 1,
  localparam int unsigned JW = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LEN_WIDTH-1:0]              s_cmd_tdata,
  input  logic                              s_cmd_tvalid,
  output logic                              s_cmd_tready,
  input  logic [U_D_WIDTH-1:0]              s_axis_w_tdata,
  input  logic                              s_axis_w_tvalid,
  output logic                              s_axis_w_tready,
  input  logic [L_R_WIDTH-1:0]              s_axis_x_tdata,
  input  logic                              s_axis_x_tvalid,
  output logic                              s_axis_x_tready,
  output logic [PE_NUMBER_I*U_D_WIDTH-1:0]  m_axis_up_tdata,
  output logic [PE_NUMBER_I-1:0]            m_axis_up_tvalid,
  output logic [PE_NUMBER_I-1:0]            m_axis_up_tlast,
  output logic [PE_NUMBER_I*USER_WIDTH-1:0] m_axis_up_tuser,
  input  logic [PE_NUMBER_I-1:0]            m_axis_up_tready,
  output logic [PE_NUMBER_J*L_R_WIDTH-1:0]  m_axis_left_tdata,
  output logic [PE_NUMBER_J-1:0]            m_axis_left_tvalid,
  output logic [PE_NUMBER_J-1:0]            m_axis_left_tlast,
  input  logic [PE_NUMBER_J-1:0]            m_axis_left_tready,
  input  logic [PE_NUMBER_I*U_D_WIDTH-1:0]  s_axis_down_tdata,
  input  logic [PE_NUMBER_I-1:0]            s_axis_down_tvalid,
  input  logic [PE_NUMBER_I-1:0]            s_axis_down_tlast,
  input  logic [PE_NUMBER_I*USER_WIDTH-1:0] s_axis_down_tuser,
  output logic [PE_NUMBER_I-1:0]            s_axis_down_tready,
  output logic [U_D_WIDTH-1:0]              m_axis_rslt_tdata,
  output logic                              m_axis_rslt_tvalid,
  output logic                              m_axis_rslt_tlast,
  output logic [IW-1:0]                     m_axis_rslt_tid,
  input  logic                              m_axis_rslt_tready,
  output logic                              busy,
  output logic                              err_cmd,
  output logic                              err_rslt
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] k_q, k_d, k_w_q, k_w_d, k_x_q, k_x_d;
  logic [IW-1:0]        col_w_q, col_w_d, c_q, c_d;
  logic [JW-1:0]        row_x_q, row_x_d, j_q, j_d;
  logic                 w_done_q, w_done_d, x_done_q, x_done_d;
  logic                 err_cmd_q, err_cmd_d;
  logic                 w_last, x_last, rslt_last;

`ifdef LPE_SCHED_RSLT_CHECK_EN
  logic                 err_rslt_q, err_rslt_d;
`else
  logic                 unused_down;
  assign unused_down = ^{s_axis_down_tuser, s_axis_down_tlast, RSLT_USER_MASK};
`endif

  // Next-state logic and combinational edge routing; everything is gated off during reset.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    k_w_d     = k_w_q;
    k_x_d     = k_x_q;
    col_w_d   = col_w_q;
    row_x_d   = row_x_q;
    c_d       = c_q;
    j_d       = j_q;
    w_done_d  = w_done_q;
    x_done_d  = x_done_q;
    err_cmd_d = err_cmd_q;
`ifdef LPE_SCHED_RSLT_CHECK_EN
    err_rslt_d = err_rslt_q;
`endif
    w_last    = (col_w_q == IW'(PE_NUMBER_I - 1)) && (k_w_q == k_q - LEN_WIDTH'(1));
    x_last    = (row_x_q == JW'(PE_NUMBER_J - 1)) && (k_x_q == k_q - LEN_WIDTH'(1));
    rslt_last = (c_q == IW'(PE_NUMBER_I - 1)) && (j_q == JW'(PE_NUMBER_J - 1));

    s_cmd_tready       = 1'b0;
    s_axis_w_tready    = 1'b0;
    s_axis_x_tready    = 1'b0;
    m_axis_up_tdata    = '0;
    m_axis_up_tvalid   = '0;
    m_axis_up_tlast    = '0;
    m_axis_up_tuser    = '0;
    m_axis_left_tdata  = '0;
    m_axis_left_tvalid = '0;
    m_axis_left_tlast  = '0;
    s_axis_down_tready = '0;
    m_axis_rslt_tdata  = '0;
    m_axis_rslt_tvalid = 1'b0;
    m_axis_rslt_tlast  = 1'b0;
    m_axis_rslt_tid    = '0;
    busy               = 1'b0;
    err_cmd            = 1'b0;
    err_rslt           = 1'b0;

    if (!rst) begin
      busy    = (state_q != StIdle);
      err_cmd = err_cmd_q;
`ifdef LPE_SCHED_RSLT_CHECK_EN
      err_rslt = err_rslt_q;
`endif
      case (state_q)
        StIdle: begin
          s_cmd_tready = 1'b1;
          if (s_cmd_tvalid) begin
            if (s_cmd_tdata == '0) begin
              err_cmd_d = 1'b1;
            end else begin
              k_d      = s_cmd_tdata;
              k_w_d    = '0;
              k_x_d    = '0;
              col_w_d  = '0;
              row_x_d  = '0;
              w_done_d = 1'b0;
              x_done_d = 1'b0;
              state_d  = StFeed;
            end
          end
        end
        StFeed: begin
          if (!w_done_q) begin
            m_axis_up_tvalid[col_w_q] = s_axis_w_tvalid;
            s_axis_w_tready           = m_axis_up_tready[col_w_q];
            m_axis_up_tdata[col_w_q*U_D_WIDTH +: U_D_WIDTH]   = s_axis_w_tdata;
            m_axis_up_tuser[col_w_q*USER_WIDTH +: USER_WIDTH] = OP1_USER_MASK;
            m_axis_up_tlast[col_w_q]  = (k_w_q == k_q - LEN_WIDTH'(1));
            if (s_axis_w_tvalid && m_axis_up_tready[col_w_q]) begin
              // Counters hold on the final word so they never run past their bounds.
              if (w_last) begin
                w_done_d = 1'b1;
              end else if (col_w_q == IW'(PE_NUMBER_I - 1)) begin
                col_w_d = '0;
                k_w_d   = k_w_q + LEN_WIDTH'(1);
              end else begin
                col_w_d = col_w_q + IW'(1);
              end
            end
          end
          if (!x_done_q) begin
            m_axis_left_tvalid[row_x_q] = s_axis_x_tvalid;
            s_axis_x_tready             = m_axis_left_tready[row_x_q];
            m_axis_left_tdata[row_x_q*L_R_WIDTH +: L_R_WIDTH] = s_axis_x_tdata;
            m_axis_left_tlast[row_x_q]  = (k_x_q == k_q - LEN_WIDTH'(1));
            if (s_axis_x_tvalid && m_axis_left_tready[row_x_q]) begin
              if (x_last) begin
                x_done_d = 1'b1;
              end else if (row_x_q == JW'(PE_NUMBER_J - 1)) begin
                row_x_d = '0;
                k_x_d   = k_x_q + LEN_WIDTH'(1);
              end else begin
                row_x_d = row_x_q + JW'(1);
              end
            end
          end
          // Leave as soon as the last word of the slower feeder is taken.
          if (w_done_d && x_done_d) begin
            c_d     = '0;
            j_d     = '0;
            state_d = StDrain;
          end
        end
        StDrain: begin
          m_axis_rslt_tvalid     = s_axis_down_tvalid[c_q];
          s_axis_down_tready[c_q] = m_axis_rslt_tready;
          m_axis_rslt_tdata      = s_axis_down_tdata[c_q*U_D_WIDTH +: U_D_WIDTH];
          m_axis_rslt_tid        = c_q;
          m_axis_rslt_tlast      = rslt_last;
          if (s_axis_down_tvalid[c_q] && m_axis_rslt_tready) begin
`ifdef LPE_SCHED_RSLT_CHECK_EN
            if (((s_axis_down_tuser[c_q*USER_WIDTH +: USER_WIDTH] & RSLT_USER_MASK) == '0) ||
                (s_axis_down_tlast[c_q] != (j_q == JW'(PE_NUMBER_J - 1)))) begin
              err_rslt_d = 1'b1;
            end
`endif
            if (rslt_last) begin
              state_d = StIdle;
            end else if (j_q == JW'(PE_NUMBER_J - 1)) begin
              j_d = '0;
              c_d = c_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and sticky error flags; synchronous reset aborts any job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      k_w_q     <= '0;
      k_x_q     <= '0;
      col_w_q   <= '0;
      row_x_q   <= '0;
      c_q       <= '0;
      j_q       <= '0;
      w_done_q  <= 1'b0;
      x_done_q  <= 1'b0;
      err_cmd_q <= 1'b0;
`ifdef LPE_SCHED_RSLT_CHECK_EN
      err_rslt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      k_w_q     <= k_w_d;
      k_x_q     <= k_x_d;
      col_w_q   <= col_w_d;
      row_x_q   <= row_x_d;
      c_q       <= c_d;
      j_q       <= j_d;
      w_done_q  <= w_done_d;
      x_done_q  <= x_done_d;
      err_cmd_q <= err_cmd_d;
`ifdef LPE_SCHED_RSLT_CHECK_EN
      err_rslt_q <= err_rslt_d;
`endif
    end
  end

endmodule

// File: tb/tb_lpe_array_scheduler.sv
// Randomised scoreboard bench for lpe_array_scheduler (2 columns x 3 rows).
module tb_lpe_array_scheduler;

  localparam int PI = 2;
  localparam int PJ = 3;

  typedef struct packed {logic [15:0] d; logic l; logic [7:0] u;} edge_t;
  typedef struct packed {logic [15:0] d; logic l; logic [0:0] tid;} rs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] cmd_tdata = '0;
  logic cmd_tvalid = 1'b0, cmd_tready;
  logic [15:0] w_tdata = '0, x_tdata = '0;
  logic w_tvalid = 1'b0, w_tready, x_tvalid = 1'b0, x_tready;
  logic [PI*16-1:0] up_tdata;
  logic [PI-1:0] up_tvalid, up_tlast;
  logic [PI*8-1:0] up_tuser;
  logic [PI-1:0] up_tready = '0;
  logic [PJ*16-1:0] left_tdata;
  logic [PJ-1:0] left_tvalid, left_tlast;
  logic [PJ-1:0] left_tready = '0;
  logic [PI*16-1:0] down_tdata = '0;
  logic [PI-1:0] down_tvalid = '0, down_tlast = '0, down_tready;
  logic [PI*8-1:0] down_tuser = '0;
  logic [15:0] rslt_tdata;
  logic rslt_tvalid, rslt_tlast, rslt_tready = 1'b0;
  logic [0:0] rslt_tid;
  logic busy, err_cmd, err_rslt;

  int checks = 0;
  int errors = 0;

  edge_t exp_up [PI][$];
  edge_t exp_left [PJ][$];
  rs_t exp_rs [$];
  logic [15:0] w_src [$];
  logic [15:0] x_src [$];
  edge_t down_src [PI][$];

  int w_cons, x_cons, nw, nx, r_cnt;
  bit in_job = 1'b0;
  bit exp_err_cmd = 1'b0;
  bit exp_err_rslt = 1'b0;

  lpe_array_scheduler #(
    .PE_NUMBER_I(PI),
    .PE_NUMBER_J(PJ),
    .U_D_WIDTH(16),
    .L_R_WIDTH(16),
    .USER_WIDTH(8),
    .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cmd_tdata(cmd_tdata), .s_cmd_tvalid(cmd_tvalid), .s_cmd_tready(cmd_tready),
    .s_axis_w_tdata(w_tdata), .s_axis_w_tvalid(w_tvalid), .s_axis_w_tready(w_tready),
    .s_axis_x_tdata(x_tdata), .s_axis_x_tvalid(x_tvalid), .s_axis_x_tready(x_tready),
    .m_axis_up_tdata(up_tdata), .m_axis_up_tvalid(up_tvalid), .m_axis_up_tlast(up_tlast),
    .m_axis_up_tuser(up_tuser), .m_axis_up_tready(up_tready),
    .m_axis_left_tdata(left_tdata), .m_axis_left_tvalid(left_tvalid),
    .m_axis_left_tlast(left_tlast), .m_axis_left_tready(left_tready),
    .s_axis_down_tdata(down_tdata), .s_axis_down_tvalid(down_tvalid),
    .s_axis_down_tlast(down_tlast), .s_axis_down_tuser(down_tuser),
    .s_axis_down_tready(down_tready),
    .m_axis_rslt_tdata(rslt_tdata), .m_axis_rslt_tvalid(rslt_tvalid),
    .m_axis_rslt_tlast(rslt_tlast), .m_axis_rslt_tid(rslt_tid),
    .m_axis_rslt_tready(rslt_tready),
    .busy(busy), .err_cmd(err_cmd), .err_rslt(err_rslt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every edge handshake the DUT makes.
  always @(negedge clk) begin
    edge_t e;
    rs_t r;
    for (int c = 0; c < PI; c++) begin
      if (up_tvalid[c] && up_tready[c]) begin
        if (exp_up[c].size() == 0) begin
          chk($sformatf("up%0d_unexpected", c), 64'(up_tvalid[c]), 64'd0);
        end else begin
          e = exp_up[c].pop_front();
          chk($sformatf("up%0d_data", c), 64'(up_tdata[c*16 +: 16]), 64'(e.d));
          chk($sformatf("up%0d_last", c), 64'(up_tlast[c]), 64'(e.l));
          chk($sformatf("up%0d_user", c), 64'(up_tuser[c*8 +: 8]), 64'(e.u));
        end
      end
    end
    for (int j = 0; j < PJ; j++) begin
      if (left_tvalid[j] && left_tready[j]) begin
        if (exp_left[j].size() == 0) begin
          chk($sformatf("left%0d_unexpected", j), 64'(left_tvalid[j]), 64'd0);
        end else begin
          e = exp_left[j].pop_front();
          chk($sformatf("left%0d_data", j), 64'(left_tdata[j*16 +: 16]), 64'(e.d));
          chk($sformatf("left%0d_last", j), 64'(left_tlast[j]), 64'(e.l));
        end
      end
    end
    if (rslt_tvalid && rslt_tready) begin
      if (exp_rs.size() == 0) begin
        chk("rslt_unexpected", 64'(rslt_tvalid), 64'd0);
      end else begin
        r = exp_rs.pop_front();
        chk("rslt_data", 64'(rslt_tdata), 64'(r.d));
        chk("rslt_tid", 64'(rslt_tid), 64'(r.tid));
        chk("rslt_last", 64'(rslt_tlast), 64'(r.l));
      end
    end
  end

  // One clock of traffic: observe handshakes, then drive new random stimulus after the edge.
  task automatic step(input bit hold1);
    logic wf, xf, rf;
    logic [PI-1:0] df;
    edge_t e;
    @(negedge clk);
    if (in_job) begin
      chk("w_tready", 64'(w_tready), 64'((w_cons < nw) && up_tready[w_cons % PI]));
      chk("x_tready", 64'(x_tready), 64'((x_cons < nx) && left_tready[x_cons % PJ]));
    end
    wf = w_tvalid && w_tready;
    xf = x_tvalid && x_tready;
    rf = rslt_tvalid && rslt_tready;
    for (int c = 0; c < PI; c++) begin
      df[c] = down_tvalid[c] && down_tready[c];
`ifdef LPE_SCHED_RSLT_CHECK_EN
      if (df[c] && !down_tuser[c*8 + 7]) exp_err_rslt = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    if (wf) begin void'(w_src.pop_front()); w_cons++; end
    if (w_src.size() > 0) begin
      if (!w_tvalid || wf) w_tvalid = ($urandom_range(3) != 0);
      w_tdata = w_src[0];
    end else w_tvalid = 1'b0;
    if (xf) begin void'(x_src.pop_front()); x_cons++; end
    if (x_src.size() > 0) begin
      if (!x_tvalid || xf) x_tvalid = ($urandom_range(3) != 0);
      x_tdata = x_src[0];
    end else x_tvalid = 1'b0;
    for (int c = 0; c < PI; c++) begin
      if (df[c]) void'(down_src[c].pop_front());
      if (down_src[c].size() > 0) begin
        if (!down_tvalid[c] || df[c]) down_tvalid[c] = ($urandom_range(3) != 0);
        e = down_src[c][0];
        down_tdata[c*16 +: 16] = e.d;
        down_tlast[c] = e.l;
        down_tuser[c*8 +: 8] = e.u;
      end else down_tvalid[c] = 1'b0;
    end
    if (rf) r_cnt++;
    up_tready = PI'($urandom | $urandom);
    if (hold1) up_tready[1] = 1'b0;
    left_tready = PJ'($urandom | $urandom);
    rslt_tready = ($urandom_range(3) != 0);
  endtask

  task automatic clear_all();
    for (int c = 0; c < PI; c++) begin exp_up[c].delete(); down_src[c].delete(); end
    for (int j = 0; j < PJ; j++) exp_left[j].delete();
    exp_rs.delete();
    w_src.delete();
    x_src.delete();
    w_tvalid = 1'b0;
    x_tvalid = 1'b0;
    down_tvalid = '0;
  endtask

  task automatic run_job(input int k, input bit bad_user, input bit do_hold, input bit rst_mid);
    edge_t e;
    rs_t r;
    logic [15:0] d;
    bit got;
    nw = k * PI; nx = k * PJ; w_cons = 0; x_cons = 0; r_cnt = 0;
    // Reference: serial word n goes to lane n % N at reduction step n / N.
    for (int n = 0; n < nw; n++) begin
      d = 16'($urandom);
      w_src.push_back(d);
      e.d = d; e.l = ((n / PI) == k - 1); e.u = 8'h40;
      exp_up[n % PI].push_back(e);
    end
    for (int n = 0; n < nx; n++) begin
      d = 16'($urandom);
      x_src.push_back(d);
      e.d = d; e.l = ((n / PJ) == k - 1); e.u = 8'h00;
      exp_left[n % PJ].push_back(e);
    end
    for (int c = 0; c < PI; c++) begin
      for (int j = 0; j < PJ; j++) begin
        d = 16'($urandom);
        e.d = d; e.l = (j == PJ - 1); e.u = (bad_user && c == 0 && j == 1) ? 8'h00 : 8'h80;
        down_src[c].push_back(e);
        r.d = d; r.l = (c == PI - 1) && (j == PJ - 1); r.tid = 1'(c);
        exp_rs.push_back(r);
      end
    end
    cmd_tdata = 16'(k);
    cmd_tvalid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = cmd_tready;
      @(posedge clk);
      #1;
    end
    cmd_tvalid = 1'b0;
    chk("cmd_accept", 64'(got), 64'd1);
    chk("busy_after_cmd", 64'(busy), 64'd1);
    in_job = 1'b1;
    for (int cyc = 0; cyc < 4000 && r_cnt < PI * PJ; cyc++) begin
      step(do_hold && cyc >= 3 && cyc < 8);
      if (rst_mid && r_cnt == 1) break;
    end
    in_job = 1'b0;
    if (rst_mid) begin
      chk("rst_mid_reached", 64'(r_cnt), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cmd_tready", 64'(cmd_tready), 64'd0);
      chk("rst_valids", 64'({up_tvalid, left_tvalid, rslt_tvalid}), 64'd0);
      chk("rst_down_tready", 64'(down_tready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_all();
      exp_err_cmd = 1'b0;
      exp_err_rslt = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_cmd_tready", 64'(cmd_tready), 64'd1);
      chk("post_rst_valids", 64'({up_tvalid, left_tvalid, rslt_tvalid}), 64'd0);
      chk("post_rst_err_cmd", 64'(err_cmd), 64'd0);
      @(posedge clk);
      #1;
    end else begin
      chk("job_done", 64'(r_cnt), 64'(PI * PJ));
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_cmd_tready", 64'(cmd_tready), 64'd1);
      chk("w_words", 64'(w_cons), 64'(nw));
      chk("x_words", 64'(x_cons), 64'(nx));
      for (int c = 0; c < PI; c++) chk("up_q_left", 64'(exp_up[c].size()), 64'd0);
      for (int j = 0; j < PJ; j++) chk("left_q_left", 64'(exp_left[j].size()), 64'd0);
      chk("err_cmd_sticky", 64'(err_cmd), 64'(exp_err_cmd));
      chk("err_rslt", 64'(err_rslt), 64'(exp_err_rslt));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_tready", 64'(cmd_tready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_errs", 64'({err_cmd, err_rslt}), 64'd0);
    chk("reset_rslt_tvalid", 64'(rslt_tvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset_tready", 64'(cmd_tready), 64'd1);
    chk("idle_after_reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // K = 0 is swallowed and flagged.
    cmd_tdata = 16'd0;
    cmd_tvalid = 1'b1;
    @(posedge clk);
    #1;
    cmd_tvalid = 1'b0;
    exp_err_cmd = 1'b1;
    chk("k0_err_cmd", 64'(err_cmd), 64'd1);
    chk("k0_busy", 64'(busy), 64'd0);

    run_job(1, 1'b0, 1'b0, 1'b0);
    run_job(3, 1'b0, 1'b0, 1'b0);
    run_job(4, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) run_job(int'($urandom_range(6, 1)), 1'b0, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0, 1'b0);
    run_job(1, 1'b0, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b0, 1'b1);
    run_job(3, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
